// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcodes, forward selects,
// and the control bundle carried from ID through EX.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Forward-source select for one EX operand; the younger EX/MEM
// result takes precedence over MEM/WB, and register 0 never forwards.
module fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        sel
);
    import id_ex_stage_pkg::*;

    logic ex_hit;
    logic wb_hit;

    assign ex_hit = exmem_reg_write && (exmem_rd != '0)
                 && (exmem_rd == src);
    assign wb_hit = memwb_reg_write && (memwb_rd != '0)
                 && (memwb_rd == src) && !ex_hit;

    always_comb begin
        sel = FWD_REG;
        unique case (1'b1)
            ex_hit:  sel = FWD_EXMEM;
            wb_hit:  sel = FWD_MEMWB;
            default: sel = FWD_REG;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use
// hazard detection; drives the ALU operands directly.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [15:0]       i_imm,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [4:0]        i_shamt,
    input  logic [OP_W-1:0]   i_ALUop,
    input  logic              i_ALUSrc,
    input  logic              i_RegDst,
    input  logic              i_RegWrite,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic              i_MemtoReg,
    input  logic              i_exmem_RegWrite,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_RegWrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic [4:0]        o_shamt,
    output logic [OP_W-1:0]   o_ALUop,
    output logic [DATA_W-1:0] o_store_data,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic              o_RegWrite,
    output logic              o_MemRead,
    output logic              o_MemWrite,
    output logic              o_MemtoReg,
    output logic              o_valid,
    output logic              o_hazard
);
    import id_ex_stage_pkg::*;

    ex_ctrl_t          ex_ctrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_wr_addr;
    logic [DATA_W-1:0] ex_rs_val;
    logic [DATA_W-1:0] ex_rt_val;
    logic [15:0]       ex_imm;
    logic [4:0]        ex_shamt;
    logic [OP_W-1:0]   ex_alu_op;
    logic              ex_alu_src;

    logic              wt_rs;
    logic              wt_rt;
    logic              load_bubble;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign o_hazard = ex_ctrl.valid && ex_ctrl.mem_read
                   && (ex_wr_addr != '0)
                   && ((ex_wr_addr == i_rs) || (ex_wr_addr == i_rt))
                   && i_valid;

    assign load_bubble = i_flush || (!i_stall && o_hazard);

    // MEM/WB retires this cycle, so its value is written through now
    assign wt_rs = i_memwb_RegWrite && (i_memwb_rd != '0)
                && (i_memwb_rd == i_rs);
    assign wt_rt = i_memwb_RegWrite && (i_memwb_rd != '0)
                && (i_memwb_rd == i_rt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl    <= CTRL_BUBBLE;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wr_addr <= '0;
            ex_rs_val  <= '0;
            ex_rt_val  <= '0;
            ex_imm     <= '0;
            ex_shamt   <= '0;
            ex_alu_op  <= OP_W'(ALU_AND);
            ex_alu_src <= 1'b0;
        end else if (load_bubble) begin
            ex_ctrl    <= CTRL_BUBBLE;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wr_addr <= '0;
            ex_rs_val  <= '0;
            ex_rt_val  <= '0;
            ex_imm     <= '0;
            ex_shamt   <= '0;
            ex_alu_op  <= OP_W'(ALU_AND);
            ex_alu_src <= 1'b0;
        end else if (!i_stall) begin
            ex_ctrl    <= '{i_valid, i_RegWrite, i_MemRead,
                            i_MemWrite, i_MemtoReg};
            ex_rs      <= i_rs;
            ex_rt      <= i_rt;
            ex_wr_addr <= i_RegDst ? i_rd : i_rt;
            ex_rs_val  <= wt_rs ? i_memwb_result : i_rs_data;
            ex_rt_val  <= wt_rt ? i_memwb_result : i_rt_data;
            ex_imm     <= i_imm;
            ex_shamt   <= i_shamt;
            ex_alu_op  <= i_ALUop;
            ex_alu_src <= i_ALUSrc;
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src             (ex_rs),
        .exmem_reg_write (i_exmem_RegWrite),
        .exmem_rd        (i_exmem_rd),
        .memwb_reg_write (i_memwb_RegWrite),
        .memwb_rd        (i_memwb_rd),
        .sel             (sel_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src             (ex_rt),
        .exmem_reg_write (i_exmem_RegWrite),
        .exmem_rd        (i_exmem_rd),
        .memwb_reg_write (i_memwb_RegWrite),
        .memwb_rd        (i_memwb_rd),
        .sel             (sel_b)
    );

    always_comb begin
        fwd_a = ex_rs_val;
        unique case (sel_a)
            FWD_EXMEM: fwd_a = i_exmem_result;
            FWD_MEMWB: fwd_a = i_memwb_result;
            default:   fwd_a = ex_rs_val;
        endcase
    end

    always_comb begin
        fwd_b = ex_rt_val;
        unique case (sel_b)
            FWD_EXMEM: fwd_b = i_exmem_result;
            FWD_MEMWB: fwd_b = i_memwb_result;
            default:   fwd_b = ex_rt_val;
        endcase
    end

    assign o_data1      = fwd_a;
    assign o_store_data = fwd_b;
    assign o_data2      = ex_alu_src
                        ? {{(DATA_W-16){ex_imm[15]}}, ex_imm}
                        : fwd_b;
    assign o_shamt      = ex_shamt;
    assign o_ALUop      = ex_alu_op;
    assign o_wr_addr    = ex_wr_addr;
    assign o_RegWrite   = ex_ctrl.reg_write;
    assign o_MemRead    = ex_ctrl.mem_read;
    assign o_MemWrite   = ex_ctrl.mem_write;
    assign o_MemtoReg   = ex_ctrl.mem_to_reg;
    assign o_valid      = ex_ctrl.valid;

endmodule
